// File: rtl/fetch_pkg.sv
// Shared constants and payload types for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned JIDX_W = 26;

    localparam logic [1:0] PCSEL_SEQ  = 2'b00;
    localparam logic [1:0] PCSEL_RS   = 2'b01;
    localparam logic [1:0] PCSEL_JUMP = 2'b10;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0;

    // One buffered fetch result as presented to decode.
    typedef struct packed {
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] instr;
    } slot_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus between fetch and imem.
interface fetch_unit_if;
    import fetch_pkg::*;

    logic            o_imem_req;
    logic [XLEN-1:0] o_imem_addr;
    logic            i_imem_ready;
    logic            i_imem_rvalid;
    logic [XLEN-1:0] i_imem_rdata;

    modport master (
        output o_imem_req, o_imem_addr,
        input  i_imem_ready, i_imem_rvalid, i_imem_rdata
    );

    modport slave (
        input  o_imem_req, o_imem_addr,
        output i_imem_ready, i_imem_rvalid, i_imem_rdata
    );

endinterface

// File: rtl/fetch_slot_queue.sv
// Circular queue of in-flight fetches: allocated at request, filled in order
// by responses, popped by decode.
module fetch_slot_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alloc,
    input  logic [XLEN-1:0] alloc_pc4,
    input  logic            fill,
    input  logic [XLEN-1:0] fill_data,
    input  logic            pop,
    input  logic            flush,
    output logic            head_valid_c,
    output slot_t           head_c,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [$clog2(DEPTH+1)-1:0] unfilled
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [PW-1:0]   head_ptr, fill_ptr, tail_ptr;
    logic [CW-1:0]   count_q, unfilled_q;
    logic [XLEN-1:0] pc4_mem   [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [DEPTH-1:0] filled;
    logic            fill_ok, pop_ok;

    // A response with nothing outstanding (e.g. from before reset) is ignored.
    assign fill_ok      = fill && (unfilled_q != '0);
    assign head_valid_c = (count_q != '0) && filled[head_ptr];
    assign pop_ok       = pop && head_valid_c;
    assign head_c       = '{pc_plus4: pc4_mem[head_ptr], instr: instr_mem[head_ptr]};
    assign count        = count_q;
    assign unfilled     = unfilled_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_ptr   <= '0;
            fill_ptr   <= '0;
            tail_ptr   <= '0;
            count_q    <= '0;
            unfilled_q <= '0;
        end else begin
            if (alloc)   tail_ptr <= tail_ptr + PW'(1);
            if (fill_ok) fill_ptr <= fill_ptr + PW'(1);
            if (pop_ok)  head_ptr <= head_ptr + PW'(1);
            count_q    <= count_q + CW'(alloc) - CW'(pop_ok);
            unfilled_q <= unfilled_q + CW'(alloc) - CW'(fill_ok);
        end
    end

    // Entry storage; validity is tracked by the pointers and count above.
    always_ff @(posedge clk) begin
        if (alloc) begin
            pc4_mem[tail_ptr] <= alloc_pc4;
            filled[tail_ptr]  <= 1'b0;
        end
        if (fill_ok) begin
            instr_mem[fill_ptr] <= fill_data;
            filled[fill_ptr]    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, redirect/halt handling, wrong-path discard and
// the slot queue feeding decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_stallD,
    input  logic [1:0]        i_pcsel,
    input  logic              i_PCSrcD,
    input  logic [XLEN-1:0]   i_branch_targetD,
    input  logic [JIDX_W-1:0] i_jump_indexD,
    input  logic [XLEN-1:0]   i_rsD,
    fetch_unit_if.master      imem,
    output logic              o_validD,
    output logic [XLEN-1:0]   o_instrD,
    output logic [XLEN-1:0]   o_pc_plus4D
);

    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam int unsigned EW = CW + 1;

    logic [XLEN-1:0] pc_q, target_c;
    logic            halted_q;
    logic [CW-1:0]   discard_q;
    logic [CW-1:0]   count, unfilled;
    logic            head_valid_c;
    slot_t           head_c;
    logic            hs, accept, halt_fire, redirect, fill_c, fill_hit_c;
    logic [EW-1:0]   discard_sum_c;

    assign hs         = imem.o_imem_req && imem.i_imem_ready;
    assign accept     = o_validD && !i_stallD;
    assign halt_fire  = accept && !i_load;
    assign redirect   = accept && i_load && ((i_pcsel != PCSEL_SEQ) || i_PCSrcD);
    assign fill_c     = imem.i_imem_rvalid && (discard_q == '0) && !halted_q;
    assign fill_hit_c = fill_c && (unfilled != '0);

    // Wrong-path responses still owed after a redirect, including a request
    // that handshakes in the redirect cycle itself.
    assign discard_sum_c = EW'(unfilled) - EW'(fill_hit_c) + EW'(hs);

    always_comb begin
        target_c = i_branch_targetD;
        case (i_pcsel)
            PCSEL_RS:   target_c = i_rsD;
            PCSEL_JUMP: target_c = {o_pc_plus4D[31:28], i_jump_indexD, 2'b00};
            default:    target_c = i_branch_targetD;
        endcase
    end

    assign imem.o_imem_req  = !rst && !halted_q && ((EW'(count) + EW'(discard_q)) < EW'(DEPTH));
    assign imem.o_imem_addr = pc_q;

    assign o_validD    = head_valid_c && !halted_q;
    assign o_instrD    = o_validD ? head_c.instr    : NOP_INSTR;
    assign o_pc_plus4D = o_validD ? head_c.pc_plus4 : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            halted_q  <= 1'b0;
            discard_q <= '0;
        end else if (halt_fire) begin
            halted_q  <= 1'b1;
            discard_q <= '0;
        end else if (redirect) begin
            pc_q      <= target_c;
            discard_q <= CW'(discard_sum_c);
        end else begin
            if (hs) pc_q <= pc_q + 32'd4;
            if ((discard_q != '0) && imem.i_imem_rvalid) discard_q <= discard_q - CW'(1);
        end
    end

    fetch_slot_queue #(.DEPTH(DEPTH)) u_queue (
        .clk          (clk),
        .rst          (rst),
        .alloc        (hs && !redirect && !halt_fire),
        .alloc_pc4    (pc_q + 32'd4),
        .fill         (fill_c),
        .fill_data    (imem.i_imem_rdata),
        .pop          (accept),
        .flush        (redirect || halt_fire),
        .head_valid_c (head_valid_c),
        .head_c       (head_c),
        .count        (count),
        .unfilled     (unfilled)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: imem model plus a decode-control table,
// with a negedge monitor checking every instruction decode accepts.
module tb_fetch_unit;
    import fetch_pkg::*;

    typedef struct { logic [31:0] addr; int due; } pend_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc4; } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_load = 1'b1, i_stallD = 1'b0, i_PCSrcD = 1'b0;
    logic [1:0]  i_pcsel = 2'b00;
    logic [31:0] i_branch_targetD = '0, i_rsD = '0;
    logic [25:0] i_jump_indexD = '0;
    logic        o_validD;
    logic [31:0] o_instrD, o_pc_plus4D;

    fetch_unit_if imem ();

    fetch_unit #(.RESET_PC(32'h0), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .i_load(i_load), .i_stallD(i_stallD),
        .i_pcsel(i_pcsel), .i_PCSrcD(i_PCSrcD), .i_branch_targetD(i_branch_targetD),
        .i_jump_indexD(i_jump_indexD), .i_rsD(i_rsD), .imem(imem),
        .o_validD(o_validD), .o_instrD(o_instrD), .o_pc_plus4D(o_pc_plus4D)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cyc = -1, lat = 1;
    int stall_from = 1000, stall_to = 0;
    bit stray_c0 = 1'b0;
    pend_t pend[$];
    exp_t  exp_q[$];
    logic [31:0] exp_addr[$];

    int          ctl_n = 0;
    int          ctl_kind[2];
    logic [31:0] ctl_pc4[2], ctl_val[2], ctl_tgt[2];
    bit          ctl_done[2];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC000_0000 ^ a;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc4);
        exp_q.push_back('{instr, pc4});
    endtask

    task automatic add_ctl(input int kind, input logic [31:0] pc4, input logic [31:0] val,
                           input logic [31:0] tgt);
        ctl_kind[ctl_n] = kind; ctl_pc4[ctl_n] = pc4; ctl_val[ctl_n] = val;
        ctl_tgt[ctl_n] = tgt;   ctl_done[ctl_n] = 1'b0;
        ctl_n++;
    endtask

    // One clock: drive memory response, decode controls and stall for this cycle.
    task automatic tick(input logic r);
        bit          tgt_arm;
        logic [31:0] tgt_val;
        @(posedge clk); #1;
        rst = r;
        if (r) begin cyc = -1; pend.delete(); end else cyc++;
        imem.i_imem_rvalid = 1'b0;
        imem.i_imem_rdata  = 32'hBAD0_BAD0;
        if (!r && pend.size() > 0 && pend[0].due <= cyc) begin
            imem.i_imem_rvalid = 1'b1;
            imem.i_imem_rdata  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else if (!r && stray_c0 && cyc == 0) begin
            imem.i_imem_rvalid = 1'b1;
            imem.i_imem_rdata  = 32'hDEAD_BEEF;
        end
        imem.i_imem_ready = 1'b1;
        i_stallD = !r && (cyc >= stall_from) && (cyc < stall_to);
        i_load = 1'b1; i_pcsel = PCSEL_SEQ; i_PCSrcD = 1'b0;
        i_branch_targetD = 32'h0BAD_0000; i_rsD = 32'h0BAD_0004; i_jump_indexD = 26'h3AB_CDEF;
        tgt_arm = 1'b0; tgt_val = '0;
        for (int k = 0; k < ctl_n; k++) begin
            if (!r && !ctl_done[k] && o_validD && o_pc_plus4D == ctl_pc4[k]) begin
                case (ctl_kind[k])
                    1: begin i_PCSrcD = 1'b1; i_branch_targetD = ctl_val[k]; end
                    2: begin i_pcsel = PCSEL_RS; i_rsD = ctl_val[k]; end
                    3: begin i_pcsel = PCSEL_JUMP; i_jump_indexD = ctl_val[k][25:0]; end
                    default: i_load = 1'b0;
                endcase
                if (!i_stallD) begin
                    ctl_done[k] = 1'b1;
                    if (ctl_kind[k] != 4) begin tgt_arm = 1'b1; tgt_val = ctl_tgt[k]; end
                end
            end
        end
        #1;
        if (imem.o_imem_req && imem.i_imem_ready) begin
            pend.push_back('{imem.o_imem_addr, cyc + lat});
            if (exp_addr.size() > 0) check("fetch_addr_after_redirect", imem.o_imem_addr, exp_addr.pop_front());
        end
        if (tgt_arm) exp_addr.push_back(tgt_val);
    endtask

    task automatic do_reset(input int latency);
        lat = latency; ctl_n = 0; stall_from = 1000; stall_to = 0; stray_c0 = 1'b0;
        tick(1'b1);
        tick(1'b1);
        check("rst_req",   32'(imem.o_imem_req), 32'd0);
        check("rst_addr",  imem.o_imem_addr,     32'h0);
        check("rst_valid", 32'(o_validD),        32'd0);
        check("rst_instr", o_instrD,             32'h0);
        check("rst_pc4",   o_pc_plus4D,          32'h0);
    endtask

    task automatic end_test(input string name);
        check(name, 32'(exp_q.size() + exp_addr.size()), 32'd0);
        exp_q.delete();
        exp_addr.delete();
    endtask

    // Scoreboard monitor: compare every accepted instruction in order.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_validD && !i_stallD) begin
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("decode_instr", o_instrD, e.instr);
                    check("decode_pc4", o_pc_plus4D, e.pc4);
                end
            end else if (!o_validD) begin
                check("idle_instr_nop", o_instrD, 32'h0);
                check("idle_pc4_zero", o_pc_plus4D, 32'h0);
            end
        end
    end

    initial begin
        imem.i_imem_ready = 1'b0; imem.i_imem_rvalid = 1'b0; imem.i_imem_rdata = '0;

        // Sequential stream, latency 1, stray response right after reset.
        do_reset(1);
        stray_c0 = 1'b1;
        for (int i = 0; i < 10; i++) push_exp(32'hC000_0000 + 32'(4*i), 32'(4*i + 4));
        for (int i = 0; i < 14; i++) begin
            tick(1'b0);
            if (cyc <= 9) begin
                check("seq_req", 32'(imem.o_imem_req), 32'd1);
                check("seq_addr", imem.o_imem_addr, 32'(4*cyc));
            end
            if (cyc >= 2 && cyc <= 11) check("seq_valid", 32'(o_validD), 32'd1);
        end
        end_test("seq_drained");

        // Taken BEQ at 0x8 -> 0x40, latency 2.
        do_reset(2);
        add_ctl(1, 32'hC, 32'h40, 32'h40);
        push_exp(32'hC000_0000, 32'h4); push_exp(32'hC000_0004, 32'h8);
        push_exp(32'hC000_0008, 32'hC); push_exp(32'hC000_0040, 32'h44);
        push_exp(32'hC000_0044, 32'h48); push_exp(32'hC000_0048, 32'h4C);
        repeat (25) tick(1'b0);
        end_test("beq_drained");

        // JR at 0x4 with rs = 0x100 while two fetches are still in flight.
        do_reset(2);
        add_ctl(2, 32'h8, 32'h100, 32'h100);
        push_exp(32'hC000_0000, 32'h4); push_exp(32'hC000_0004, 32'h8);
        push_exp(32'hC000_0100, 32'h104); push_exp(32'hC000_0104, 32'h108);
        repeat (25) tick(1'b0);
        end_test("jr_drained");

        // JR into 0x1000_000C, then J with index 0x40 from pc+4 0x1000_0010.
        do_reset(1);
        add_ctl(2, 32'h4, 32'h1000_000C, 32'h1000_000C);
        add_ctl(3, 32'h1000_0010, 32'h0000_0040, 32'h1000_0100);
        push_exp(32'hC000_0000, 32'h4);
        push_exp(32'hD000_000C, 32'h1000_0010);
        push_exp(32'hD000_0100, 32'h1000_0104);
        push_exp(32'hD000_0104, 32'h1000_0108);
        repeat (20) tick(1'b0);
        end_test("j_drained");

        // Decode stall for cycles 3..7 with the pc=0x4 instruction at the head.
        do_reset(1);
        stall_from = 3; stall_to = 8;
        for (int i = 0; i < 8; i++) push_exp(32'hC000_0000 + 32'(4*i), 32'(4*i + 4));
        for (int i = 0; i < 16; i++) begin
            tick(1'b0);
            if (cyc >= 3 && cyc <= 7) begin
                check("stall_instr", o_instrD, 32'hC000_0004);
                check("stall_valid", 32'(o_validD), 32'd1);
            end
            if (cyc == 3 || cyc == 4 || cyc == 9) check("stall_req_on", 32'(imem.o_imem_req), 32'd1);
            if (cyc >= 5 && cyc <= 8) check("stall_req_off", 32'(imem.o_imem_req), 32'd0);
        end
        end_test("stall_drained");

        // HALT at pc 0x8, then freeze for 20 cycles, then restart from reset.
        do_reset(1);
        add_ctl(4, 32'hC, 32'h0, 32'h0);
        push_exp(32'hC000_0000, 32'h4); push_exp(32'hC000_0004, 32'h8);
        push_exp(32'hC000_0008, 32'hC);
        repeat (5) tick(1'b0);
        for (int i = 0; i < 20; i++) begin
            tick(1'b0);
            check("halt_req", 32'(imem.o_imem_req), 32'd0);
            check("halt_valid", 32'(o_validD), 32'd0);
        end
        end_test("halt_drained");
        do_reset(1);
        exp_addr.push_back(32'h0);
        push_exp(32'hC000_0000, 32'h4); push_exp(32'hC000_0004, 32'h8);
        repeat (6) tick(1'b0);
        end_test("restart_drained");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the pipelined MIPS core. It owns the fetch PC, issues in-order read requests to a variable-latency instruction memory, and buffers returned words in a small slot queue. It presents one instruction per cycle to the decode stage, whose control outputs come back as redirect and halt commands. It applies jump, jump-register, and branch redirects from decode with no delay slot, squashing wrong-path fetches, and freezes permanently on HALT.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- DEPTH, 4, slot queue entries; power of two; must be ≥ 2 (≥ 3 for full throughput at 1-cycle memory latency)

- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- i_load  in  1  decode load enable; 0 = HALT in decode
- i_stallD  in  1  hazard stall; decode does not accept this cycle
- i_pcsel  in  2  00 sequential/branch, 01 Rs (JR/JALR), 10 jump (J/JAL)
- i_PCSrcD  in  1  resolved branch-taken from decode
- i_branch_targetD  in  32  branch target computed in decode
- i_jump_indexD  in  26  instruction index field of J/JAL in decode
- i_rsD  in  32  forwarded Rs value for JR/JALR
- o_imem_req  out  1  read request valid
- o_imem_addr  out  32  word address being requested (current fetch PC)
- i_imem_ready  in  1  memory accepts request this cycle
- i_imem_rvalid  in  1  response valid; responses return in request order
- i_imem_rdata  in  32  response instruction word
- o_validD  out  1  o_instrD/o_pc_plus4D hold a valid instruction
- o_instrD  out  32  instruction to decode; 32'h0 (NOP) when not valid
- o_pc_plus4D  out  32  PC+4 of presented instruction; 0 when not valid

## Operation
- Slot queue: an entry is allocated when a request handshake (o_imem_req && i_imem_ready) occurs. The entry stores {pc+4, filled=0}.
- i_imem_rvalid fills the oldest unfilled entry with rdata.
- The head is presented when filled.
- Accept: o_validD && !i_stallD pops the head.
- Fetch PC advances by 4 on each request handshake.
- o_imem_req = !rst && !halted && (allocated + discard_cnt) < DEPTH.
- Redirect fires when an accept occurs and (i_pcsel != 00 || i_PCSrcD). The target is chosen in priority order:
  - pcsel 01: i_rsD.
  - pcsel 10: {o_pc_plus4D[31:28], i_jump_indexD, 2'b00}.
  - otherwise: i_branch_targetD.
- On redirect:
  - fetch PC is set to the target;
  - every allocated entry is flushed;
  - discard_cnt is set to the number of unfilled entries, plus 1 if a request handshake occurs the same cycle (that request is wrong-path).
- While discard_cnt > 0, each rvalid is dropped and decrements discard_cnt.
- rvalid with no outstanding request is ignored.
- Halt fires when an accept occurs with i_load == 0.
  - Sets halted and flushes the queue.
  - Outstanding responses are dropped.
  - o_imem_req and o_validD stay 0 until rst.
- Halt and redirect cannot coincide, because HALT decodes pcsel = 00 and PCSrcD = 0. If both ever occur, halt wins.
- Stall: the head is held and outputs are stable. Requests continue while credit remains.

## Timing
- Reset values: o_imem_req 0, o_imem_addr RESET_PC, o_validD 0, o_instrD 0, o_pc_plus4D 0. Queue empty, discard_cnt 0, halted 0.
- Reset mid-operation drops all state. Responses arriving after reset for pre-reset requests are ignored, because no entry is outstanding.
- First request is asserted in the cycle after rst deasserts.
- Request accepted in cycle t, rvalid in t+1 → o_validD in t+2. The fill is registered; there is no rdata→o_instrD bypass.
- Redirect accepted in cycle t → request to the target in t+1. The first target instruction is presented at t+3 at the earliest.
- Sustained throughput is 1 instruction/cycle when DEPTH ≥ 3 and memory latency is 1.
- The PC wraps modulo 2^32.

## Structure
- Shared package fetch_pkg holds:
  - PCSEL_SEQ = 2'b00, PCSEL_RS = 2'b01, PCSEL_JUMP = 2'b10, matching the main decoder encoding;
  - NOP_INSTR = 32'h0.
- Sub-module fetch_slot_queue: DEPTH-entry circular queue with alloc, fill (oldest unfilled), pop and flush ports. It has separate head, fill and tail pointers plus an occupancy count.
- Top level holds the fetch PC, redirect mux, discard counter and halted flag.

## Test plan
- Reset then run, with memory latency 1, always ready, and 10 sequential instructions. o_imem_addr must be 0x0, 0x4, …, 0x24 on consecutive cycles, and o_validD must stay high every cycle from cycle 2 onward.
- Taken BEQ at pc 0x8 with target 0x40 and latency 2. Words from 0xC/0x10 must never reach decode, and the next o_instrD must be mem[0x40] with o_pc_plus4D = 0x44.
- JR with i_rsD = 0x100 accepted while 2 requests are outstanding. Those 2 responses must be dropped (discard_cnt 2→0), and the next fetch address must be 0x100.
- J with o_pc_plus4D = 0x1000_0010 and index 26'h0000040. The next fetch address must be 0x1000_0100.
- i_stallD held for 5 cycles with DEPTH = 4. o_instrD must stay stable, o_imem_req must drop after 4 allocations, and fetch must resume in order after release.
- HALT with i_load = 0 accepted. o_imem_req and o_validD must stay 0 for 20 cycles. rst must restart fetch at RESET_PC.
